// File: rtl/seg_check_pkg.sv
// Shared types for segment_collision_checker: walk states, error-term sizing
// and the packed cell coordinate used by the in-flight coordinate FIFO.
package seg_check_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Container width for a cell coordinate; grid coordinates are zero-extended into it.
   localparam int unsigned COORD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } cell_t;

   // Signed Bresenham error width: larger axis plus sign and one guard bit.
   function automatic int unsigned err_width(input int unsigned wx, input int unsigned wy);
      return ((wx > wy) ? wx : wy) + 2;
   endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO of cell coordinates, one entry per grid query in flight.
// rd_data_c is the combinational head entry; full/empty are registered.
module coord_fifo
   import seg_check_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  logic  pop,
   input  cell_t wr_data,
   output cell_t rd_data_c,
   output logic  full,
   output logic  empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   cell_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      count_nxt = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/segment_collision_checker.sv
// Walks the Bresenham line between two grid cells, querying occupancy_grid per cell.
// Optional COLLISION_CELL_EN adds hit_x/hit_y reporting the first occupied cell.
module segment_collision_checker
   import seg_check_pkg::*;
#(
   parameter int unsigned GRID_WIDTH_LOG2  = 6,
   parameter int unsigned GRID_HEIGHT_LOG2 = 6,
   parameter int unsigned MAX_OUTSTANDING  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        seg_vld,
   output logic                        seg_rdy,
   input  logic [GRID_WIDTH_LOG2-1:0]  x0,
   input  logic [GRID_HEIGHT_LOG2-1:0] y0,
   input  logic [GRID_WIDTH_LOG2-1:0]  x1,
   input  logic [GRID_HEIGHT_LOG2-1:0] y1,
   output logic                        res_vld,
   input  logic                        res_rdy,
   output logic                        collision,
   output logic [GRID_WIDTH_LOG2-1:0]  grid_cell_x,
   output logic [GRID_HEIGHT_LOG2-1:0] grid_cell_y,
   output logic                        grid_vld,
   input  logic                        grid_rdy,
   output logic                        grid_we,
   output logic                        grid_w_occupied,
   input  logic                        grid_resp_vld,
   input  logic                        grid_r_occupied
`ifdef COLLISION_CELL_EN
   ,
   output logic [GRID_WIDTH_LOG2-1:0]  hit_x,
   output logic [GRID_HEIGHT_LOG2-1:0] hit_y
`endif
);

   localparam int unsigned XW = GRID_WIDTH_LOG2;
   localparam int unsigned YW = GRID_HEIGHT_LOG2;
   localparam int unsigned EW = err_width(XW, YW);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   state_t               state, state_nxt;
   logic [XW-1:0]        cell_x_nxt, end_x, end_x_nxt;
   logic [YW-1:0]        cell_y_nxt, end_y, end_y_nxt;
   logic signed [EW-1:0] dx, dx_nxt, dy, dy_nxt, err, err_nxt;
   logic                 step_xn, step_xn_nxt, step_yn, step_yn_nxt;
   logic [OW-1:0]        outstanding, outstanding_nxt;
   logic                 coll_flag, coll_flag_nxt;
   logic                 last_issued, last_issued_nxt;
   logic                 seg_rdy_nxt, res_vld_nxt, collision_nxt, grid_vld_nxt;

   logic                 query_acc, resp_take, resp_hit, at_end;
   logic [XW-1:0]        adx;
   logic [YW-1:0]        ady;
   logic signed [EW-1:0] dx_in, dy_mag, dy_in;
   logic signed [EW:0]   e2, dx_ext, dy_ext;
   logic signed [EW-1:0] err_step;
   logic [XW-1:0]        x_step;
   logic [YW-1:0]        y_step;

   assign grid_we         = 1'b0;
   assign grid_w_occupied = 1'b0;

   // Responses only count while something is in flight; strays after reset are dropped.
   always_comb begin
      query_acc = grid_vld & grid_rdy;
      resp_take = grid_resp_vld & (outstanding != '0);
      resp_hit  = resp_take & grid_r_occupied;
      at_end    = (grid_cell_x == end_x) && (grid_cell_y == end_y);
   end

   // Initial Bresenham terms from the raw endpoints.
   always_comb begin
      adx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
      ady    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
      dx_in  = EW'(adx);
      dy_mag = EW'(ady);
      dy_in  = -dy_mag;
   end

   // One Bresenham step from the current cell; both tests use the pre-step e2.
   always_comb begin
      e2       = {err, 1'b0};
      dx_ext   = {dx[EW-1], dx};
      dy_ext   = {dy[EW-1], dy};
      err_step = err;
      x_step   = grid_cell_x;
      y_step   = grid_cell_y;
      if (e2 >= dy_ext) begin
         err_step = err_step + dy;
         x_step   = step_xn ? (grid_cell_x - XW'(1)) : (grid_cell_x + XW'(1));
      end
      if (e2 <= dx_ext) begin
         err_step = err_step + dx;
         y_step   = step_yn ? (grid_cell_y - YW'(1)) : (grid_cell_y + YW'(1));
      end
   end

   always_comb begin
      state_nxt       = state;
      cell_x_nxt      = grid_cell_x;
      cell_y_nxt      = grid_cell_y;
      end_x_nxt       = end_x;
      end_y_nxt       = end_y;
      dx_nxt          = dx;
      dy_nxt          = dy;
      err_nxt         = err;
      step_xn_nxt     = step_xn;
      step_yn_nxt     = step_yn;
      outstanding_nxt = outstanding + OW'(query_acc) - OW'(resp_take);
      coll_flag_nxt   = coll_flag | resp_hit;
      last_issued_nxt = last_issued;
      seg_rdy_nxt     = seg_rdy;
      res_vld_nxt     = res_vld;
      collision_nxt   = collision;
      grid_vld_nxt    = grid_vld;

      case (state)
         IDLE: begin
            seg_rdy_nxt   = 1'b1;
            grid_vld_nxt  = 1'b0;
            coll_flag_nxt = 1'b0;
            if (seg_vld && seg_rdy) begin
               state_nxt       = WALK;
               cell_x_nxt      = x0;
               cell_y_nxt      = y0;
               end_x_nxt       = x1;
               end_y_nxt       = y1;
               dx_nxt          = dx_in;
               dy_nxt          = dy_in;
               err_nxt         = dx_in + dy_in;
               step_xn_nxt     = (x1 < x0);
               step_yn_nxt     = (y1 < y0);
               last_issued_nxt = 1'b0;
               seg_rdy_nxt     = 1'b0;
               grid_vld_nxt    = 1'b1;
            end
         end

         WALK: begin
            if (query_acc) begin
               if (at_end) begin
                  last_issued_nxt = 1'b1;
               end else begin
                  cell_x_nxt = x_step;
                  cell_y_nxt = y_step;
                  err_nxt    = err_step;
               end
            end
            // A collision abandons even a held query; otherwise a pending query stays put.
            if (last_issued_nxt || coll_flag_nxt) begin
               state_nxt    = DRAIN;
               grid_vld_nxt = 1'b0;
            end else if (grid_vld && !grid_rdy) begin
               grid_vld_nxt = 1'b1;
            end else begin
               grid_vld_nxt = (outstanding_nxt < OW'(MAX_OUTSTANDING));
            end
         end

         DRAIN: begin
            grid_vld_nxt = 1'b0;
            if (outstanding_nxt == '0) begin
               state_nxt     = DONE;
               res_vld_nxt   = 1'b1;
               collision_nxt = coll_flag_nxt;
            end
         end

         DONE: begin
            if (res_rdy) begin
               state_nxt     = IDLE;
               res_vld_nxt   = 1'b0;
               collision_nxt = 1'b0;
               coll_flag_nxt = 1'b0;
               seg_rdy_nxt   = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         grid_cell_x <= '0;
         grid_cell_y <= '0;
         end_x       <= '0;
         end_y       <= '0;
         dx          <= '0;
         dy          <= '0;
         err         <= '0;
         step_xn     <= 1'b0;
         step_yn     <= 1'b0;
         outstanding <= '0;
         coll_flag   <= 1'b0;
         last_issued <= 1'b0;
         seg_rdy     <= 1'b1;
         res_vld     <= 1'b0;
         collision   <= 1'b0;
         grid_vld    <= 1'b0;
      end else begin
         state       <= state_nxt;
         grid_cell_x <= cell_x_nxt;
         grid_cell_y <= cell_y_nxt;
         end_x       <= end_x_nxt;
         end_y       <= end_y_nxt;
         dx          <= dx_nxt;
         dy          <= dy_nxt;
         err         <= err_nxt;
         step_xn     <= step_xn_nxt;
         step_yn     <= step_yn_nxt;
         outstanding <= outstanding_nxt;
         coll_flag   <= coll_flag_nxt;
         last_issued <= last_issued_nxt;
         seg_rdy     <= seg_rdy_nxt;
         res_vld     <= res_vld_nxt;
         collision   <= collision_nxt;
         grid_vld    <= grid_vld_nxt;
      end
   end

`ifdef COLLISION_CELL_EN
   cell_t issued_cell;
   cell_t fifo_head;
   logic  fifo_full;
   logic  fifo_empty;
   logic  unused_fifo_bits;

   always_comb begin
      issued_cell.x = COORD_W'(grid_cell_x);
      issued_cell.y = COORD_W'(grid_cell_y);
   end

   // Head entry always matches the query whose response is on the bus.
   coord_fifo #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_coord_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (query_acc & ~fifo_full),
      .pop       (resp_take & ~fifo_empty),
      .wr_data   (issued_cell),
      .rd_data_c (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign unused_fifo_bits = ^fifo_head;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_x <= '0;
         hit_y <= '0;
      end else if (resp_hit && !coll_flag) begin
         hit_x <= XW'(fifo_head.x);
         hit_y <= YW'(fifo_head.y);
      end
   end
`else
   // Without hit reporting only the outstanding counter tracks in-flight queries.
`endif

endmodule

// File: tb/tb_segment_collision_checker.sv
// Scoreboard bench for segment_collision_checker with a behavioural occupancy_grid
// model (configurable latency and ready pattern) and directed segments.
module tb_segment_collision_checker;

   localparam int unsigned XW   = 6;
   localparam int unsigned YW   = 6;
   localparam int unsigned MAXO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          seg_vld;
   logic          seg_rdy;
   logic [XW-1:0] x0, x1;
   logic [YW-1:0] y0, y1;
   logic          res_vld;
   logic          res_rdy;
   logic          collision;
   logic [XW-1:0] grid_cell_x;
   logic [YW-1:0] grid_cell_y;
   logic          grid_vld;
   logic          grid_rdy;
   logic          grid_we;
   logic          grid_w_occupied;
   logic          grid_resp_vld;
   logic          grid_r_occupied;
`ifdef COLLISION_CELL_EN
   logic [XW-1:0] hit_x;
   logic [YW-1:0] hit_y;
`endif

   always #5 clk = ~clk;

   segment_collision_checker #(
      .GRID_WIDTH_LOG2  (XW),
      .GRID_HEIGHT_LOG2 (YW),
      .MAX_OUTSTANDING  (MAXO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .seg_vld         (seg_vld),
      .seg_rdy         (seg_rdy),
      .x0              (x0),
      .y0              (y0),
      .x1              (x1),
      .y1              (y1),
      .res_vld         (res_vld),
      .res_rdy         (res_rdy),
      .collision       (collision),
      .grid_cell_x     (grid_cell_x),
      .grid_cell_y     (grid_cell_y),
      .grid_vld        (grid_vld),
      .grid_rdy        (grid_rdy),
      .grid_we         (grid_we),
      .grid_w_occupied (grid_w_occupied),
      .grid_resp_vld   (grid_resp_vld),
      .grid_r_occupied (grid_r_occupied)
`ifdef COLLISION_CELL_EN
      ,
      .hit_x           (hit_x),
      .hit_y           (hit_y)
`endif
   );

   typedef struct {int due; int x; int y;} pend_t;
   typedef struct {int coll; int hx; int hy;} res_t;

   pend_t       pend_q[$];
   int          exp_q[$];
   res_t        exp_res[$];
   logic [63:0] occ [64];

   int n_cmp    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int latency  = 1;
   int rdy_mode = 0;
   int acc_cnt  = 0;
   bit occ_seen = 1'b0;
   bit tog      = 1'b0;

   function automatic int cc(input int x, input int y);
      return x * 256 + y;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout, expected completion (t=%0t)", name, $time);
   endtask

   task automatic expect_cells(input int cells[$]);
      foreach (cells[i]) exp_q.push_back(cells[i]);
   endtask

   task automatic expect_res(input int coll, input int hx, input int hy);
      res_t r;
      r.coll = coll;
      r.hx   = hx;
      r.hy   = hy;
      exp_res.push_back(r);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_seg_rdy"},   int'(seg_rdy),     1);
      chk({tag, "_res_vld"},   int'(res_vld),     0);
      chk({tag, "_collision"}, int'(collision),   0);
      chk({tag, "_grid_vld"},  int'(grid_vld),    0);
      chk({tag, "_cell_x"},    int'(grid_cell_x), 0);
      chk({tag, "_cell_y"},    int'(grid_cell_y), 0);
   endtask

   // Called right after a posedge (+2); returns just after the accepting posedge.
   task automatic send_seg(input int a, input int b, input int c, input int d, output int waited);
      occ_seen = 1'b0;
      x0 = XW'(a);
      y0 = YW'(b);
      x1 = XW'(c);
      y1 = YW'(d);
      seg_vld = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (seg_rdy) break;
         waited++;
         if (waited > 300) begin
            timeout_fail("seg_accept");
            break;
         end
      end
      @(posedge clk);
      #2;
      seg_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (exp_res.size() != 0 || exp_q.size() != 0 || pend_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 400) begin
            timeout_fail({tag, "_done"});
            exp_q.delete();
            exp_res.delete();
            break;
         end
      end
      @(posedge clk);
      #2;
   endtask

   // occupancy_grid model plus query-side monitor.
   initial begin : grid_model
      bit    acc;
      int    ax, ay, hx, hy;
      bit    prev_hold;
      pend_t p;
      prev_hold = 1'b0;
      hx = 0;
      hy = 0;
      grid_rdy = 1'b1;
      grid_resp_vld = 1'b0;
      grid_r_occupied = 1'b0;
      forever begin
         @(negedge clk);
         acc = grid_vld && grid_rdy;
         ax  = int'(grid_cell_x);
         ay  = int'(grid_cell_y);
         if (prev_hold && rst_n && !occ_seen) begin
            chk("hold_vld", int'(grid_vld), 1);
            chk("hold_cell", cc(ax, ay), cc(hx, hy));
         end
         prev_hold = rst_n && grid_vld && !grid_rdy;
         hx = ax;
         hy = ay;
         if (acc && rst_n) begin
            acc_cnt++;
            chk("inflight_le_max", int'(pend_q.size() + 1 <= MAXO), 1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL query_unexpected: got (%0d,%0d), expected none", ax, ay);
            end else begin
               chk("query_cell", cc(ax, ay), exp_q.pop_front());
            end
         end
         @(posedge clk);
         cyc++;
         #1;
         if (acc && rst_n) begin
            p.due = cyc + latency;
            p.x = ax;
            p.y = ay;
            pend_q.push_back(p);
         end
         grid_resp_vld = 1'b0;
         grid_r_occupied = 1'b0;
         if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
            p = pend_q.pop_front();
            grid_resp_vld = 1'b1;
            grid_r_occupied = occ[p.y][p.x];
            if (occ[p.y][p.x]) occ_seen = 1'b1;
         end
         case (rdy_mode)
            0: grid_rdy = 1'b1;
            1: begin
               tog = ~tog;
               grid_rdy = tog;
            end
            default: grid_rdy = 1'b0;
         endcase
      end
   end

   // Result-side monitor.
   initial begin : res_monitor
      res_t e;
      forever begin
         @(negedge clk);
         if (rst_n && res_vld && res_rdy) begin
            chk("drained_before_result", pend_q.size(), 0);
            if (exp_res.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL result_unexpected: got collision=%0d, expected none", collision);
            end else begin
               e = exp_res.pop_front();
               chk("collision", int'(collision), e.coll);
`ifdef COLLISION_CELL_EN
               if (e.coll != 0) begin
                  chk("hit_x", int'(hit_x), e.hx);
                  chk("hit_y", int'(hit_y), e.hy);
               end
`endif
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int w;
      int base;
      int n;
      for (int i = 0; i < 64; i++) occ[i] = '0;
      rst_n   = 1'b0;
      seg_vld = 1'b0;
      res_rdy = 1'b1;
      x0 = '0;
      y0 = '0;
      x1 = '0;
      y1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // 1: empty grid, latency 1
      expect_cells('{cc(0,0), cc(1,0), cc(2,1), cc(3,1), cc(4,2), cc(5,2)});
      expect_res(0, 0, 0);
      send_seg(0, 0, 5, 2, w);
      wait_done("t1");

      // 2: (3,1) occupied; (4,2) is already in flight when the hit returns
      occ[1][3] = 1'b1;
      expect_cells('{cc(0,0), cc(1,0), cc(2,1), cc(3,1), cc(4,2)});
      expect_res(1, 3, 1);
      send_seg(0, 0, 5, 2, w);
      wait_done("t2");
      occ[1][3] = 1'b0;

      // 3: degenerate segment, free then occupied
      expect_cells('{cc(7,7)});
      expect_res(0, 0, 0);
      send_seg(7, 7, 7, 7, w);
      wait_done("t3a");
      occ[7][7] = 1'b1;
      expect_cells('{cc(7,7)});
      expect_res(1, 7, 7);
      send_seg(7, 7, 7, 7, w);
      wait_done("t3b");
      occ[7][7] = 1'b0;

      // 4: latency 6, grid_rdy toggling
      latency  = 6;
      rdy_mode = 1;
      expect_cells('{cc(10,3), cc(9,4), cc(8,5), cc(7,5), cc(6,6),
                     cc(5,7), cc(4,8), cc(3,8), cc(2,9)});
      expect_res(0, 0, 0);
      send_seg(10, 3, 2, 9, w);
      wait_done("t4");
      latency  = 1;
      rdy_mode = 0;

      // 5: result back-pressure, then back-to-back segment
      occ[2][4] = 1'b1;
      res_rdy = 1'b0;
      expect_cells('{cc(2,2), cc(3,2), cc(4,2)});
      expect_res(1, 4, 2);
      send_seg(2, 2, 4, 2, w);
      n = 0;
      forever begin
         @(negedge clk);
         if (res_vld) break;
         n++;
         if (n > 200) begin
            timeout_fail("t5_res_vld");
            break;
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_res_vld_hold",   int'(res_vld),   1);
         chk("t5_collision_hold", int'(collision), 1);
         chk("t5_seg_rdy_low",    int'(seg_rdy),   0);
         chk("t5_no_query",       int'(grid_vld),  0);
      end
      occ[2][4] = 1'b0;
      @(posedge clk);
      #2;
      res_rdy = 1'b1;
      expect_cells('{cc(7,7)});
      expect_res(0, 0, 0);
      send_seg(7, 7, 7, 7, w);
      chk("t5_b2b_wait", w, 1);
      wait_done("t5");

      // 6: reset with 3 queries outstanding, late responses ignored
      latency = 6;
      expect_cells('{cc(0,0), cc(1,0), cc(2,1), cc(3,1), cc(4,2), cc(5,2)});
      base = acc_cnt;
      send_seg(0, 0, 5, 2, w);
      n = 0;
      while (acc_cnt < base + 3) begin
         @(posedge clk);
         #2;
         n++;
         if (n > 100) begin
            timeout_fail("t6_three_issued");
            break;
         end
      end
      rst_n    = 1'b0;
      rdy_mode = 2;
      grid_rdy = 1'b0;
      @(posedge clk);
      #2;
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n    = 1'b1;
      rdy_mode = 0;
      grid_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_reset_outputs("t6_post_reset");
      end
      chk("t6_late_resp_flushed", pend_q.size(), 0);
      @(posedge clk);
      #2;
      latency = 1;
      expect_cells('{cc(0,0), cc(1,1)});
      expect_res(0, 0, 0);
      send_seg(0, 0, 1, 1, w);
      wait_done("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/segment_collision_checker.md
Name: segment_collision_checker

Overview:
Initiator for the occupancy_grid query interface. It accepts a line segment in grid-cell coordinates and walks every cell on the Bresenham line between the endpoints, endpoints included. For each cell it issues a read query to occupancy_grid, keeping up to MAX_OUTSTANDING queries in flight. It reports whether any cell is occupied and sits between the RRT edge-extension logic and occupancy_grid.

Parameters:
GRID_WIDTH_LOG2, 6, bits of x cell coordinate
GRID_HEIGHT_LOG2, 6, bits of y cell coordinate
MAX_OUTSTANDING, 4, max in-flight grid queries (power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
seg_vld  in  1  segment request valid
seg_rdy  out  1  checker can accept a segment
x0  in  GRID_WIDTH_LOG2  start x
y0  in  GRID_HEIGHT_LOG2  start y
x1  in  GRID_WIDTH_LOG2  end x
y1  in  GRID_HEIGHT_LOG2  end y
res_vld  out  1  result valid
res_rdy  in  1  result consumer ready
collision  out  1  1 = some cell on the segment is occupied
grid_cell_x  out  GRID_WIDTH_LOG2  query x, to occupancy_grid cell_x_in
grid_cell_y  out  GRID_HEIGHT_LOG2  query y, to occupancy_grid cell_y_in
grid_vld  out  1  query valid, to occupancy_grid vld_in
grid_rdy  in  1  from occupancy_grid rdy
grid_we  out  1  constant 0
grid_w_occupied  out  1  constant 0
grid_resp_vld  in  1  from occupancy_grid vld_out
grid_r_occupied  in  1  from occupancy_grid r_occupied

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, seg_rdy=1, res_vld=0, collision=0, grid_vld=0, grid_cell_x/y=0, outstanding=0.
- Handshakes are valid/ready. A transfer occurs on a cycle with vld&&rdy. grid_vld, grid_cell_x and grid_cell_y hold stable until grid_rdy.
- Grid responses return in issue order, one per accepted query, with arbitrary latency >= 1 cycle.
- IDLE: seg_rdy=1. On seg_vld, latch the endpoints and compute:
  - dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 by sign, err=dx+dy.
  - err is signed, width max(GRID_WIDTH_LOG2,GRID_HEIGHT_LOG2)+2, no overflow possible.
  - Go to WALK with current cell=(x0,y0).
- WALK:
  - seg_rdy=0. grid_vld=1 while outstanding<MAX_OUTSTANDING and no collision has been seen.
  - On an accepted query, if current cell==(x1,y1), mark the last cell issued. Otherwise do one Bresenham step: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
  - outstanding increments on query accept and decrements on grid_resp_vld. If both happen in the same cycle, it is unchanged.
  - A response with grid_r_occupied=1 sets the sticky collision flag. grid_vld drops from the next cycle.
  - Leave for DRAIN when the last cell is issued or the collision flag is set.
- DRAIN: no new queries. Absorb responses (further occupied responses are harmless). When outstanding==0, go to DONE.
- DONE: res_vld=1, collision=flag. On res_rdy, go to IDLE and clear the flag.
- Cells queried when no collision occurs = max(dx,|dy|)+1. A degenerate segment (x0==x1, y0==y1) issues exactly 1 query.
- No wrap-around: coordinates stay within the endpoints' bounding box.
- Responses arriving in IDLE when outstanding==0, e.g. after a mid-operation reset, are ignored. Mid-operation reset drops the segment and emits no result.

Optional Feature:
COLLISION_CELL_EN:
- Defined: adds outputs hit_x [GRID_WIDTH_LOG2] and hit_y [GRID_HEIGHT_LOG2], valid with res_vld when collision=1. They give the coordinates of the first occupied cell in walk order.
- Implemented by pushing issued coordinates into a MAX_OUTSTANDING-deep FIFO on query accept and popping on each response. Capture happens on the first occupied response only.
- Undefined: no FIFO and no hit ports; only the outstanding counter is kept.

Decomposition:
- Package seg_check_pkg:
  - state enum {IDLE, WALK, DRAIN, DONE}
  - ERR_WIDTH localparam function
  - packed cell_t struct {x, y}
- Sub-module coord_fifo (synchronous FIFO of cell_t, depth MAX_OUTSTANDING, push/pop/full/empty). Instantiated only under COLLISION_CELL_EN.

Test Plan:
1. Empty grid, grid_rdy=1, latency 1, segment (0,0)->(5,2) -> exactly 6 queries in order (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); res_vld with collision=0.
2. Cell (3,1) occupied, same segment -> collision=1, no query issued beyond those in flight at detection, outstanding drains to 0 before res_vld; hit=(3,1) with COLLISION_CELL_EN.
3. Degenerate segment (7,7)->(7,7), cell free -> exactly 1 query at (7,7), collision=0; cell occupied -> collision=1.
4. Grid latency 6, grid_rdy toggling 1010, segment (10,3)->(2,9) -> at most MAX_OUTSTANDING=4 in flight, query held stable during rdy=0, 9 queries, correct order.
5. res_rdy held 0 for 5 cycles -> res_vld and collision stay stable, seg_rdy=0, no queries; then a back-to-back second segment is accepted the cycle after IDLE.
6. rst_n=0 during WALK with 3 queries outstanding, late responses then arrive -> all outputs at reset values, responses ignored; a new segment (0,0)->(1,1) then checks correctly.
